// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: direction-mode encodings, arctangent table, gain.
package cordic_pkg;

  typedef enum logic [1:0] {
    CORDIC_EXT = 2'd0,
    CORDIC_ROT = 2'd1,
    CORDIC_VEC = 2'd2,
    CORDIC_RSV = 2'd3
  } cordic_mode_e;

  localparam int unsigned ATAN_ENTRIES = 16;
  localparam int unsigned ATAN_PREC    = 32;

  // atan(2^-i) with pi = 2^31, kept at 32 bits and truncated to the angle width on use
  localparam logic [ATAN_PREC-1:0] ATAN_TAB [ATAN_ENTRIES] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C
  };

  // Uncompensated magnitude gain of a long CORDIC chain
  localparam real CORDIC_GAIN = 1.6467602581210654;

  // Table entry rescaled so that pi maps to 2^(zw-1)
  function automatic logic [ATAN_PREC-1:0] atan_entry(input int unsigned idx,
                                                      input int unsigned zw);
    return ATAN_TAB[idx] >> (ATAN_PREC - zw);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation with its pipeline register; shift amount is IDX.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned IDX  = 0,
  parameter int unsigned W    = 16,
  parameter int unsigned ZW   = 16,
  parameter int unsigned NDIR = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic            valid_i,
  input  logic [W-1:0]    x_i,
  input  logic [W-1:0]    y_i,
  input  logic [ZW-1:0]   z_i,
  input  logic [1:0]      mode_i,
  input  logic [NDIR-1:0] dir_i,
  output logic            valid_o,
  output logic [W-1:0]    x_o,
  output logic [W-1:0]    y_o,
  output logic [ZW-1:0]   z_o,
  output logic [1:0]      mode_o,
  output logic [NDIR-1:0] dir_o
);

  localparam logic [ZW-1:0] ATAN_I = ZW'(atan_entry(IDX, ZW));

  logic            valid_q;
  logic [W-1:0]    x_q, y_q;
  logic [ZW-1:0]   z_q;
  logic [1:0]      mode_q;
  logic [NDIR-1:0] dir_q;

  logic            neg_d;
  logic [W-1:0]    x_sh, y_sh;
  logic [W-1:0]    x_d, y_d;
  logic [ZW-1:0]   z_d;

  // Direction select and shift/add/sub for this micro-rotation
  always_comb begin
    neg_d = 1'b0;
    x_sh  = W'($signed(x_i) >>> IDX);
    y_sh  = W'($signed(y_i) >>> IDX);
    x_d   = x_i;
    y_d   = y_i;
    z_d   = z_i;
    case (cordic_mode_e'(mode_i))
      CORDIC_ROT: neg_d = z_i[ZW-1];
      CORDIC_VEC: neg_d = ~y_i[W-1];
      default:    neg_d = dir_i[IDX];
    endcase
    if (neg_d) begin
      x_d = x_i + y_sh;
      y_d = y_i - x_sh;
      z_d = z_i + ATAN_I;
    end else begin
      x_d = x_i - y_sh;
      y_d = y_i + x_sh;
      z_d = z_i - ATAN_I;
    end
  end

  // Stage register; data only loads with a real sample so held results stay put
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= '0;
      dir_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        x_q    <= x_d;
        y_q    <= y_d;
        z_q    <= z_d;
        mode_q <= mode_i;
        dir_q  <= dir_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign mode_o  = mode_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/cordic_pipe_gen.sv
// Elastic fully pipelined CORDIC engine: STAGES micro-rotations with bubble collapse.
module cordic_pipe_gen
  import cordic_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned ZW     = 16,
  parameter int unsigned STAGES = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [STAGES-1:0] in_dir,
  input  logic [W-1:0]      in_x,
  input  logic [W-1:0]      in_y,
  input  logic [ZW-1:0]     in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_x,
  output logic [W-1:0]      out_y,
  output logic [ZW-1:0]     out_z,
  output logic [1:0]        out_mode
);

  // Index k is the input of stage k; index k+1 is its registered output
  logic [STAGES:0]              valid_s;
  logic [STAGES-1:0]            ready_s;
  logic [STAGES:0][W-1:0]       x_s;
  logic [STAGES:0][W-1:0]       y_s;
  logic [STAGES:0][ZW-1:0]      z_s;
  logic [STAGES:0][1:0]         mode_s;
  logic [STAGES:0][STAGES-1:0]  dir_s;

  assign valid_s[0] = in_valid;
  assign x_s[0]     = in_x;
  assign y_s[0]     = in_y;
  assign z_s[0]     = in_z;
  assign mode_s[0]  = in_mode;
  assign dir_s[0]   = in_dir;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k can load when any later stage has a hole or the consumer takes the tail
    assign ready_s[k] = out_ready | ~(&valid_s[STAGES:k+1]);

    cordic_stage #(
      .IDX  (k),
      .W    (W),
      .ZW   (ZW),
      .NDIR (STAGES)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (ready_s[k]),
      .valid_i (valid_s[k]),
      .x_i     (x_s[k]),
      .y_i     (y_s[k]),
      .z_i     (z_s[k]),
      .mode_i  (mode_s[k]),
      .dir_i   (dir_s[k]),
      .valid_o (valid_s[k+1]),
      .x_o     (x_s[k+1]),
      .y_o     (y_s[k+1]),
      .z_o     (z_s[k+1]),
      .mode_o  (mode_s[k+1]),
      .dir_o   (dir_s[k+1])
    );
  end

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[STAGES];
  assign out_x     = x_s[STAGES];
  assign out_y     = y_s[STAGES];
  assign out_z     = z_s[STAGES];
  assign out_mode  = mode_s[STAGES];

endmodule

// File: tb/tb_cordic_pipe_gen.sv
// Randomised scoreboard bench for cordic_pipe_gen against an arithmetic reference.
module tb_cordic_pipe_gen;

  localparam int unsigned W      = 16;
  localparam int unsigned ZW     = 16;
  localparam int unsigned STAGES = 10;
  localparam real         PI     = 3.14159265358979323846;
  // A 10-step CORDIC leaves up to ~atan(2^-9) of angle unresolved, plus table truncation
  localparam int          TOL_Z  = 24;
  localparam int          TOL_XY = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [STAGES-1:0] in_dir;
  logic [W-1:0]      in_x, in_y;
  logic [ZW-1:0]     in_z;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_x, out_y;
  logic [ZW-1:0]     out_z;
  logic [1:0]        out_mode;

  cordic_pipe_gen #(.W(W), .ZW(ZW), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_dir    (in_dir),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint x, y, z;
    int     mode;
    longint acc_cyc;
    bit     chk_lat;
    bit     approx;
    longint ax, ay, az;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  int     rdy_mode = 0;
  int     accepts = 0;
  int     outs = 0;
  int     first_drop_at = -1;
  longint atan_q[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_near(input string name, input longint act, input longint req,
                            input longint tol);
    longint diff;
    diff = (act > req) ? act - req : req - act;
    checks++;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, tol);
    end
  endtask

  function automatic longint wrapn(input longint v, input int n);
    longint m, u;
    m = longint'(1) << n;
    u = v & (m - 1);
    return (u >= (m >> 1)) ? u - m : u;
  endfunction

  function automatic longint sx(input logic [31:0] v, input int n);
    return wrapn(longint'(v), n);
  endfunction

  // Reference: iterate the micro-rotations on signed integers, wrapping every step
  task automatic model(input longint xi, input longint yi, input longint zi, input int m,
                       input logic [STAGES-1:0] dir, output exp_t e);
    longint x, y, z, nx, ny, d;
    bit neg;
    x = wrapn(xi, W);
    y = wrapn(yi, W);
    z = wrapn(zi, ZW);
    for (int i = 0; i < int'(STAGES); i++) begin
      if (m == 1)      neg = (z < 0);
      else if (m == 2) neg = (y >= 0);
      else             neg = dir[i];
      d  = neg ? -1 : 1;
      nx = wrapn(x - d * (y >>> i), W);
      ny = wrapn(y + d * (x >>> i), W);
      z  = wrapn(z - d * atan_q[i], ZW);
      x  = nx;
      y  = ny;
    end
    e.x = x; e.y = y; e.z = z; e.mode = m;
    e.acc_cyc = 0; e.chk_lat = 1'b0; e.approx = 1'b0;
    e.ax = 0; e.ay = 0; e.az = 0;
  endtask

  // Present one sample, hold it until accepted, push its expectation on transfer
  task automatic send(input longint x, input longint y, input longint z, input int m,
                      input logic [STAGES-1:0] dir, input bit chk_lat, input bit approx,
                      input longint ax, input longint ay, input longint az);
    exp_t e;
    int   waitc;
    model(x, y, z, m, dir, e);
    e.chk_lat = chk_lat; e.approx = approx;
    e.ax = ax; e.ay = ay; e.az = az;
    in_x = W'(x); in_y = W'(y); in_z = ZW'(z);
    in_mode = 2'(m); in_dir = dir; in_valid = 1'b1;
    waitc = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.acc_cyc = cyc;
        q.push_back(e);
        accepts++;
        @(posedge clk); #1;
        break;
      end
      if (first_drop_at < 0) first_drop_at = accepts;
      @(posedge clk); #1;
      waitc++;
      if (waitc > 500) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit any_mode);
    int m;
    m = any_mode ? int'($urandom_range(0, 3)) : 0;
    send(longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
         longint'($urandom_range(0, 65535)), m, STAGES'($urandom), 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, longint'(q.size()), 0);
  endtask

  // Consumer handshake driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 0);
    end
  end

  // Monitor: whatever the DUT presents must equal the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = q[0];
        check("out_x", sx(32'(out_x), W), e.x);
        check("out_y", sx(32'(out_y), W), e.y);
        check("out_z", sx(32'(out_z), ZW), e.z);
        check("out_mode", longint'(out_mode), longint'(e.mode));
        if (e.chk_lat) check("latency", cyc - e.acc_cyc, longint'(STAGES));
        if (e.approx) begin
          check_near("approx_x", sx(32'(out_x), W), e.ax, TOL_XY);
          check_near("approx_y", sx(32'(out_y), W), e.ay, TOL_XY);
          check_near("approx_z", sx(32'(out_z), ZW), e.az, TOL_Z);
        end
        if (out_ready) begin
          void'(q.pop_front());
          outs++;
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++)
      atan_q[i] = longint'($floor($atan(2.0 ** (-i)) / PI * (2.0 ** (ZW - 1)) + 1.0e-9));

    reset = 1'b1; in_valid = 1'b0; in_mode = '0; in_dir = '0;
    in_x = '0; in_y = '0; in_z = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_x", longint'(out_x), 0);
    check("rst_out_z", longint'(out_z), 0);
    check("rst_out_mode", longint'(out_mode), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1 check("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed samples, consumer always ready so latency is exact
    send(9949, 0, 8192, 1, '0, 1'b1, 1'b1, 11585, 11585, 0);
    send(10000, 10000, 0, 2, '0, 1'b1, 1'b1, 23289, 0, 8192);
    send(1000, 0, 0, 0, 10'h000, 1'b1, 1'b0, 0, 0, 0);
    send(1000, 0, 0, 0, 10'h3FF, 1'b1, 1'b0, 0, 0, 0);
    send(1000, 0, 0, 3, 10'h3FF, 1'b1, 1'b0, 0, 0, 0);
    send(-2000, 700, 123, 0, 10'h155, 1'b1, 1'b0, 0, 0, 0);
    send(-2000, 700, 123, 3, 10'h155, 1'b1, 1'b0, 0, 0, 0);
    send(32767, 32767, 0, 0, 10'h000, 1'b1, 1'b0, 0, 0, 0);
    send(-20000, 5000, -12000, 1, '0, 1'b1, 1'b0, 0, 0, 0);
    drain("directed");

    // Backpressure: consumer stalled 20 cycles, then random readiness
    rdy_mode = 1; out_ready = 1'b0;
    accepts = 0; outs = 0; first_drop_at = -1;
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(1'b1);
      end
      begin
        repeat (20) @(posedge clk);
        rdy_mode = 2;
      end
    join
    check("bp_accepts", longint'(accepts), 40);
    check("bp_first_drop", longint'(first_drop_at), longint'(STAGES));
    rdy_mode = 0;
    drain("backpressure");
    check("bp_outputs", longint'(outs), 40);

    // Reset with samples in flight and the tail stalled
    rdy_mode = 1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_rand(1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_valid_before_reset", longint'(out_valid), 1);
    @(negedge clk); #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_x", longint'(out_x), 0);
    check("mid_rst_out_y", longint'(out_y), 0);
    check("mid_rst_out_z", longint'(out_z), 0);
    check("mid_rst_out_mode", longint'(out_mode), 0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b1;
    #1 check("mid_rst_in_ready", longint'(in_ready), 1);
    rdy_mode = 0; out_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(3000, -4000, 5000, 1, '0, 1'b1, 1'b0, 0, 0, 0);
    drain("after_reset");

    // Random traffic with random consumer readiness
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) send_rand(1'b1);
    rdy_mode = 0;
    drain("random");
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
